// File: rtl/shift_deser.sv
`default_nettype none
// ============================================================================
// Module   : shift_deser
// Brief    : Serial-to-parallel receiver with valid/ready holding register.
// Revision : 1.0 - initial release
// ============================================================================
module shift_deser #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         ser_in,
  input  logic                         ser_valid,
  input  logic                         dir,
  output logic [WIDTH-1:0]             p_out,
  output logic                         p_valid,
  input  logic                         p_ready,
  output logic                         overflow,
  output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

  localparam int CW = $clog2(WIDTH+1);

  localparam logic [0:0] c_st_idle  = 1'b0;
  localparam logic [0:0] c_st_shift = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic             r_dir;
  logic [WIDTH-1:0] r_p_out;
  logic             r_p_valid;
  logic             r_overflow;

  logic             w_dir_eff;
  logic [WIDTH-1:0] w_next_sreg;
  logic             w_last;
  logic             w_consume;

  // Direction is taken live on the first bit, then held for the rest of the word.
  assign w_dir_eff   = (r_state == c_st_idle) ? dir : r_dir;
  assign w_next_sreg = w_dir_eff ? {ser_in, r_sreg[WIDTH-1:1]}
                                 : {r_sreg[WIDTH-2:0], ser_in};
  assign w_last      = ser_valid && (r_cnt == CW'(WIDTH-1));
  assign w_consume   = r_p_valid && p_ready;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_st_idle;
      r_sreg     <= '0;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_p_out    <= '0;
      r_p_valid  <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_state    <= c_st_idle;
      r_sreg     <= '0;
      r_cnt      <= '0;
      r_p_valid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (ser_valid) begin
        if (r_state == c_st_idle) begin
          r_dir <= dir;
        end
        if (w_last) begin
          r_state <= c_st_idle;
          r_sreg  <= '0;
          r_cnt   <= '0;
        end else begin
          r_state <= c_st_shift;
          r_sreg  <= w_next_sreg;
          r_cnt   <= r_cnt + CW'(1);
        end
      end

      // A completed word can only land if the holding register is free this edge.
      if (w_last) begin
        if (!r_p_valid || p_ready) begin
          r_p_out   <= w_next_sreg;
          r_p_valid <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end else if (w_consume) begin
        r_p_valid <= 1'b0;
      end
    end
  end

  assign p_out    = r_p_out;
  assign p_valid  = r_p_valid;
  assign overflow = r_overflow;
  assign bit_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_shift_deser.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_deser
// Brief    : Scoreboard bench for shift_deser (WIDTH=4), directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_deser;

  localparam int WIDTH = 4;
  localparam int CW    = $clog2(WIDTH+1);

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             ser_in;
  logic             ser_valid;
  logic             dir;
  logic [WIDTH-1:0] p_out;
  logic             p_valid;
  logic             p_ready;
  logic             overflow;
  logic [CW-1:0]    bit_cnt;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];
  logic             stim_done = 1'b0;

  shift_deser #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .clear(clear), .ser_in(ser_in), .ser_valid(ser_valid),
    .dir(dir), .p_out(p_out), .p_valid(p_valid), .p_ready(p_ready),
    .overflow(overflow), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one negedge worth of inputs, applied just after the rising edge.
  task automatic step(input logic v, input logic b, input logic d, input logic rdy);
    @(posedge clk); #1;
    ser_valid = v; ser_in = b; dir = d; p_ready = rdy; clear = 1'b0;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic send_word(input logic [3:0] w, input logic d, input logic rdy);
    for (int i = 3; i >= 0; i--) step(1'b1, w[i], d, rdy);
  endtask

  // Monitor: a word is newly presented when p_valid is high and either it was
  // low last sample or the previous word was consumed at the intervening edge.
  logic prev_valid = 1'b0;
  always @(posedge clk) begin
    if (p_valid && (!prev_valid || p_ready)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %b expected none", p_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = sb.pop_front();
        check("sb_word", int'(p_out), int'(e));
      end
    end
    prev_valid = p_valid;
  end

  initial begin
    rst = 1'b1; clear = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; dir = 1'b0; p_ready = 1'b0;
    #12;
    check("reset_p_out", int'(p_out), 0);
    check("reset_p_valid", int'(p_valid), 0);
    check("reset_overflow", int'(overflow), 0);
    check("reset_bit_cnt", int'(bit_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;

    // 1: MSB-first 1,0,1,1 with consumer ready
    sb.push_back(4'b1011);
    step(1, 1, 0, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    settle();
    check("t1_p_out", int'(p_out), 4'b1011);
    check("t1_p_valid", int'(p_valid), 1);
    check("t1_bit_cnt", int'(bit_cnt), 0);
    step(0, 0, 0, 1); settle();
    check("t1_pulse_drop", int'(p_valid), 0);
    check("t1_overflow", int'(overflow), 0);

    // 2: LSB-first 1,0,1,1, dir toggled after the first bit
    sb.push_back(4'b1101);
    step(1, 1, 1, 1); step(1, 0, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
    settle();
    check("t2_p_out", int'(p_out), 4'b1101);
    step(0, 0, 0, 1);

    // 3: MSB-first 1,1,0,0 with 3-cycle gaps
    sb.push_back(4'b1100);
    begin
      logic [3:0] w3;
      w3 = 4'b1100;
      for (int i = 3; i >= 0; i--) begin
        step(1, w3[i], 0, 1); settle();
        check("t3_bit_cnt", int'(bit_cnt), (4 - i) % 4);
        for (int g = 0; g < 3; g++) step(0, 0, 1, 1);
      end
    end
    check("t3_p_out", int'(p_out), 4'b1100);

    // 4: overflow while held, then clear
    sb.push_back(4'b1010);
    send_word(4'b1010, 0, 0);
    send_word(4'b0101, 0, 0);
    settle();
    check("t4_p_out", int'(p_out), 4'b1010);
    check("t4_p_valid", int'(p_valid), 1);
    check("t4_overflow", int'(overflow), 1);
    step(1, 1, 0, 1); clear = 1'b1; settle();
    check("t4_clr_p_valid", int'(p_valid), 0);
    check("t4_clr_overflow", int'(overflow), 0);
    check("t4_clr_bit_cnt", int'(bit_cnt), 0);
    check("t4_clr_p_out", int'(p_out), 4'b1010);

    // 5: completion coinciding with consume
    sb.push_back(4'b0011);
    send_word(4'b0011, 0, 0);
    sb.push_back(4'b1001);
    step(1, 1, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 1, 0, 1);
    settle();
    check("t5_p_out", int'(p_out), 4'b1001);
    check("t5_p_valid", int'(p_valid), 1);
    check("t5_overflow", int'(overflow), 0);
    step(0, 0, 0, 1); settle();
    check("t5_consumed", int'(p_valid), 0);

    // 6: reset mid-word
    step(1, 1, 0, 1); step(1, 1, 0, 1);
    @(posedge clk); #1 rst = 1'b1; ser_valid = 1'b0; #1;
    check("t6_rst_p_out", int'(p_out), 0);
    check("t6_rst_p_valid", int'(p_valid), 0);
    check("t6_rst_overflow", int'(overflow), 0);
    check("t6_rst_bit_cnt", int'(bit_cnt), 0);
    @(posedge clk); #1 rst = 1'b0;
    sb.push_back(4'b0110);
    send_word(4'b0110, 0, 1);
    settle();
    check("t6_p_out", int'(p_out), 4'b0110);
    step(0, 0, 0, 1);

    repeat (4) @(posedge clk);
    check("sb_drained", sb.size(), 0);
    stim_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    if (!stim_done) begin
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
    end
  end

endmodule
`default_nettype wire
